// File: rtl/fifo_ctrl.sv
// fifo_ctrl
// ---------------------------------------------------------------------------
// This is a synchronous FIFO controller for a dual-port block RAM whose read
// port is registered. The RAM output register serves as the head-of-queue
// register, so the consumer sees a first-word-fall-through pop interface.
//
// Handshake semantics:
//   - Push is accepted when wr=1 and full=0. wr_data is captured in that cycle.
//     A wr while full is dropped and raises overflow in the next cycle.
//   - Pop is accepted when rd=1 and empty=0. It consumes the word on dout.
//     A rd while empty is ignored and raises underflow in the next cycle.
//   - Neither side stalls the other. wr/rd are requests, and full/empty say
//     whether each request is taken this cycle.
//
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   wr, wr_data           : push request and data
//   rd                    : pop request
//   dout, empty           : head-of-queue word (from ram_rdata) and its valid flag
//   full, count           : occupancy flags and total occupancy (0..DEPTH)
//   overflow, underflow   : one-cycle error pulses
//   ram_we/waddr/wdata    : RAM write port
//   ram_re/raddr, ram_rdata : RAM read port (registered read data)
// ---------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full_w;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  fetch;
  logic [CW-1:0]         mem_count;

  assign full_w = (count_q == CW'(DEPTH));

  always_comb begin
    push_ok     = 1'b0;
    pop_ok      = 1'b0;
    fetch       = 1'b0;
    mem_count   = '0;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    // Words still in RAM that have not been loaded into the output register.
    mem_count = count_q - CW'(out_valid_q);

    // While reset is high, no RAM access is started. The state registers are
    // cleared in the flop block.
    push_ok = wr & ~full_w & ~reset;
    pop_ok  = rd & out_valid_q & ~reset;

    // Refill the head register when it is empty or is being consumed.
    // mem_count == 0 means the only candidate word is the one being written
    // this cycle, so the RAM never sees a read and write to one address at once.
    fetch = (mem_count != '0) & (~out_valid_q | pop_ok) & ~reset;

    if (push_ok) wptr_d = wptr_q + ADDR_WIDTH'(1);
    if (fetch)   rptr_d = rptr_q + ADDR_WIDTH'(1);

    if (fetch)       out_valid_d = 1'b1;
    else if (pop_ok) out_valid_d = 1'b0;

    count_d = count_q + CW'(push_ok) - CW'(pop_ok);

    overflow_d  = wr & full_w;
    underflow_d = rd & ~out_valid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign dout      = ram_rdata;
  assign empty     = ~out_valid_q;
  assign full      = full_w;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign ram_we    = push_ok;
  assign ram_waddr = wptr_q;
  assign ram_wdata = wr_data;
  assign ram_re    = fetch;
  assign ram_raddr = rptr_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// This testbench drives fifo_ctrl against a behavioural registered-read RAM.
// A vector table covers reset, underflow, single-word latency and the
// push+pop case at count==1. Hand-written sequences cover fill/drain,
// wrap-around, steady push+pop, full with push+pop, and reset mid-stream.
module tb_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          wr;
  logic [DW-1:0] wr_data;
  logic          rd;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .wr_data   (wr_data),
    .rd        (rd),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_re    (ram_re),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural dual-port RAM with registered read data.
  logic [DW-1:0] mem [DEPTH];
  initial ram_rdata = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            mdl_count;
  int            checks;
  int            errors;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // This task runs one cycle of push and/or pop. rd is issued only where the
  // sequence guarantees a valid head word, so each rd pops the scoreboard.
  task automatic do_cycle(input logic w, input logic [DW-1:0] d, input logic r);
    logic acc;
    reset   = 1'b0;
    wr      = w;
    wr_data = d;
    rd      = r;
    #1;
    acc = w && (mdl_count < DEPTH);
    chk("ram_we", int'(ram_we), int'(acc));
    if (r) begin
      chk("pop_valid", int'(empty), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data actual=%0d expected=none (queue empty)", dout);
      end else begin
        chk("pop_data", int'(dout), int'(exp_q.pop_front()));
      end
    end
    if (acc) exp_q.push_back(d);
    mdl_count = mdl_count + int'(acc) - int'(r);
    @(posedge clk);
    #1;
    chk("count", int'(count), mdl_count);
    chk("full", int'(full), int'(mdl_count == DEPTH));
    chk("overflow", int'(overflow), int'(w && !acc));
    chk("underflow", int'(underflow), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mdl_count = 0;
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          wr;
    logic [DW-1:0] d;
    logic          rd;
    logic          e_we;
    logic          e_re;
    logic          e_empty;
    logic          e_full;
    logic [AW:0]   e_count;
    logic          e_ovf;
    logic          e_unf;
    logic          chk_dout;
    logic [DW-1:0] e_dout;
  } vec_t;

  vec_t vecs[13];

  initial begin
    checks    = 0;
    errors    = 0;
    mdl_count = 0;
    reset     = 1'b1;
    wr        = 1'b0;
    rd        = 1'b0;
    wr_data   = '0;
    repeat (2) @(posedge clk);
    #1;

    //          rst wr d      rd  we re  emp ful cnt ovf unf chk dout
    vecs[0]  = '{1, 1, 8'h00, 1,  0, 0,  1,  0,  0,  0,  0,  0,  8'h00}; // wr/rd ignored in reset
    vecs[1]  = '{0, 0, 8'h00, 0,  0, 0,  1,  0,  0,  0,  0,  0,  8'h00};
    vecs[2]  = '{0, 0, 8'h00, 1,  0, 0,  1,  0,  0,  0,  1,  0,  8'h00}; // underflow
    vecs[3]  = '{0, 0, 8'h00, 0,  0, 0,  1,  0,  0,  0,  0,  0,  8'h00}; // pulse ends
    vecs[4]  = '{0, 1, 8'hA5, 0,  1, 0,  1,  0,  1,  0,  0,  0,  8'h00}; // push, count=1
    vecs[5]  = '{0, 0, 8'h00, 0,  0, 1,  0,  0,  1,  0,  0,  1,  8'hA5}; // fetch, dout valid
    vecs[6]  = '{0, 0, 8'h00, 1,  0, 0,  1,  0,  0,  0,  0,  0,  8'h00}; // pop
    vecs[7]  = '{0, 0, 8'h00, 0,  0, 0,  1,  0,  0,  0,  0,  0,  8'h00};
    vecs[8]  = '{0, 1, 8'h11, 0,  1, 0,  1,  0,  1,  0,  0,  0,  8'h00};
    vecs[9]  = '{0, 0, 8'h00, 0,  0, 1,  0,  0,  1,  0,  0,  1,  8'h11};
    vecs[10] = '{0, 1, 8'h22, 1,  1, 0,  1,  0,  1,  0,  0,  0,  8'h00}; // push+pop at count 1
    vecs[11] = '{0, 0, 8'h00, 0,  0, 1,  0,  0,  1,  0,  0,  1,  8'h22};
    vecs[12] = '{0, 0, 8'h00, 1,  0, 0,  1,  0,  0,  0,  0,  0,  8'h00};

    for (int i = 0; i < 13; i++) begin
      reset   = vecs[i].rst;
      wr      = vecs[i].wr;
      wr_data = vecs[i].d;
      rd      = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_we", i), int'(ram_we), int'(vecs[i].e_we));
      chk($sformatf("v%0d_re", i), int'(ram_re), int'(vecs[i].e_re));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].e_empty));
      chk($sformatf("v%0d_full", i), int'(full), int'(vecs[i].e_full));
      chk($sformatf("v%0d_count", i), int'(count), int'(vecs[i].e_count));
      chk($sformatf("v%0d_ovf", i), int'(overflow), int'(vecs[i].e_ovf));
      chk($sformatf("v%0d_unf", i), int'(underflow), int'(vecs[i].e_unf));
      if (vecs[i].chk_dout) chk($sformatf("v%0d_dout", i), int'(dout), int'(vecs[i].e_dout));
    end
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;

    // The bench idles for 10 cycles with no RAM activity.
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b0, 8'h00, 1'b0);
      chk("idle_re", int'(ram_re), 0);
      chk("idle_empty", int'(empty), 1);
    end

    // The bench fills the FIFO to full, then pushes once more to overflow it.
    for (int k = 0; k < DEPTH; k++) do_cycle(1'b1, 8'(k), 1'b0);
    do_cycle(1'b1, 8'hEE, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < DEPTH; k++) do_cycle(1'b0, 8'h00, 1'b1);
    chk("drain_empty", int'(empty), 1);

    // Three rounds of 10 pushes and 10 pops wrap the pointers.
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 0; k < 10; k++) do_cycle(1'b1, 8'(8'h40 + rnd * 10 + k), 1'b0);
      repeat (2) do_cycle(1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 10; k++) do_cycle(1'b0, 8'h00, 1'b1);
      chk("wrap_empty", int'(empty), 1);
    end

    // Steady-state push+pop holds count at 5.
    for (int k = 0; k < 5; k++) do_cycle(1'b1, 8'(8'h80 + k), 1'b0);
    repeat (2) do_cycle(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 20; k++) do_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    for (int k = 0; k < 5; k++) do_cycle(1'b0, 8'h00, 1'b1);
    chk("steady_empty", int'(empty), 1);

    // At full, push+pop takes only the pop.
    for (int k = 0; k < DEPTH; k++) do_cycle(1'b1, 8'(8'hC0 + k), 1'b0);
    repeat (2) do_cycle(1'b0, 8'h00, 1'b0);
    do_cycle(1'b1, 8'h5A, 1'b1);
    chk("fullrw_count", int'(count), DEPTH - 1);
    for (int k = 0; k < DEPTH - 1; k++) do_cycle(1'b0, 8'h00, 1'b1);
    chk("fullrw_empty", int'(empty), 1);

    // Reset mid-stream discards contents; a new word appears two cycles after its push.
    for (int k = 0; k < 7; k++) do_cycle(1'b1, 8'(8'h20 + k), 1'b0);
    repeat (2) do_cycle(1'b0, 8'h00, 1'b0);
    do_reset();
    do_cycle(1'b1, 8'h3C, 1'b0);
    chk("post_rst_empty_c1", int'(empty), 1);
    do_cycle(1'b0, 8'h00, 1'b0);
    chk("post_rst_empty_c2", int'(empty), 0);
    do_cycle(1'b0, 8'h00, 1'b1);
    chk("post_rst_final_empty", int'(empty), 1);

    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
